program_memory_loadable: RTL

- Next-generation program memory for the single-cycle RISC-V core: a synchronous-read instruction RAM that a byte-serial boot loader (UART/debug path) fills at run time, replacing the fixed file-initialised ROM.
- Byte-addressed fetch port with base-address relocation, alignment and range checking, and one-cycle registered read with a valid strobe.
- Sits between the PC/fetch stage and the boot-loader byte stream.

---
 rtl/program_memory_loadable.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/program_memory_loadable.sv
// Loadable instruction RAM: a byte-serial boot loader fills the image, then the
// fetch port serves relocated, range-checked words with one-cycle latency.
module program_memory_loadable #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013,
  localparam int unsigned BPW = DATA_WIDTH / 8,
  localparam int unsigned AW  = $clog2(MEMORY_DEPTH),
  localparam int unsigned LW  = $clog2(BPW)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load_Start_i,
  input  logic                  Byte_Valid_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Last_i,
  output logic                  Byte_Ready_o,
  output logic                  Load_Done_o,
  output logic [AW:0]           Words_Loaded_o,
  output logic                  Run_o,
  input  logic                  Fetch_Req_i,
  input  logic [31:0]           Address_i,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic                  Instr_Valid_o,
  output logic                  Fetch_Error_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] NOP_L     = DATA_WIDTH'(NOP_WORD);
  localparam logic [LW-1:0]         LANE_MAX  = LW'(BPW - 1);
  localparam logic [AW:0]           PTR_LAST  = (AW + 1)'(MEMORY_DEPTH - 1);

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [AW:0]             wr_ptr_r;
  logic [LW-1:0]           lane_r;
  logic [DATA_WIDTH-1:0]   asm_r;
  logic [AW:0]             words_loaded_r;
  logic                    ready_r;
  logic                    run_r;
  logic                    load_done_r;
  logic [DATA_WIDTH-1:0]   instr_r;
  logic                    valid_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   ram_r [MEMORY_DEPTH];

  logic                    accept_s;
  logic                    wr_en_s;
  logic                    finish_s;
  logic                    fetch_s;
  logic [DATA_WIDTH-1:0]   word_s;
  logic [31:0]             offset_s;
  logic [31:0]             index_s;
  logic                    fetch_err_s;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; a load start always wins over byte or fetch traffic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (Load_Start_i) state_nx_s = ST_LOADING;
        else              state_nx_s = ST_EMPTY;
      end
      ST_LOADING: begin
        if (Load_Start_i)  state_nx_s = ST_LOADING;
        else if (finish_s) state_nx_s = ST_RUN;
        else               state_nx_s = ST_LOADING;
      end
      ST_RUN: begin
        if (Load_Start_i) state_nx_s = ST_LOADING;
        else              state_nx_s = ST_RUN;
      end
      default: state_nx_s = ST_EMPTY;
    endcase
  end

  // Per-state control strobes for the loader and fetch datapaths.
  always_comb begin
    accept_s = 1'b0;
    wr_en_s  = 1'b0;
    finish_s = 1'b0;
    fetch_s  = 1'b0;
    case (state_r)
      ST_LOADING: begin
        accept_s = Byte_Valid_i & ~Load_Start_i;
        wr_en_s  = accept_s & (Byte_Last_i | (lane_r == LANE_MAX));
        finish_s = accept_s & (Byte_Last_i | (wr_en_s & (wr_ptr_r == PTR_LAST)));
      end
      ST_RUN: begin
        fetch_s = Fetch_Req_i & ~Load_Start_i;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Merge the incoming byte into its little-endian lane; lanes not yet filled stay zero.
  always_comb begin
    word_s = asm_r;
    word_s[{lane_r, 3'b000} +: 8] = Byte_i;
  end

  // Relocate and range-check the fetch address against the loaded image.
  always_comb begin
    offset_s    = Address_i - BASE_ADDRESS;
    index_s     = offset_s >> LW;
    fetch_err_s = (Address_i < BASE_ADDRESS)
                | (offset_s[LW-1:0] != {LW{1'b0}})
                | (index_s >= {{(31 - AW){1'b0}}, words_loaded_r});
  end

  // Loader write pointer, lane counter, assembly register and image size.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r       <= {(AW + 1){1'b0}};
      lane_r         <= {LW{1'b0}};
      asm_r          <= {DATA_WIDTH{1'b0}};
      words_loaded_r <= {(AW + 1){1'b0}};
    end else if (Load_Start_i) begin
      wr_ptr_r       <= {(AW + 1){1'b0}};
      lane_r         <= {LW{1'b0}};
      asm_r          <= {DATA_WIDTH{1'b0}};
      words_loaded_r <= {(AW + 1){1'b0}};
    end else if (wr_en_s) begin
      wr_ptr_r       <= wr_ptr_r + (AW + 1)'(1);
      lane_r         <= {LW{1'b0}};
      asm_r          <= {DATA_WIDTH{1'b0}};
      words_loaded_r <= wr_ptr_r + (AW + 1)'(1);
    end else if (accept_s) begin
      lane_r <= lane_r + LW'(1);
      asm_r  <= word_s;
    end else begin
      lane_r <= lane_r;
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ram_r[wr_ptr_r[AW-1:0]] <= word_s;
    end
  end

  // Registered status outputs follow the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r     <= 1'b0;
      run_r       <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      ready_r     <= (state_nx_s == ST_LOADING);
      run_r       <= (state_nx_s == ST_RUN);
      load_done_r <= finish_s;
    end
  end

  // Fetch response register: data holds between responses, error only with valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r <= NOP_L;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= fetch_s;
      err_r   <= fetch_s & fetch_err_s;
      if (fetch_s) begin
        instr_r <= fetch_err_s ? NOP_L : ram_r[index_s[AW-1:0]];
      end
    end
  end

  assign Byte_Ready_o   = ready_r;
  assign Load_Done_o    = load_done_r;
  assign Words_Loaded_o = words_loaded_r;
  assign Run_o          = run_r;
  assign Instruction_o  = instr_r;
  assign Instr_Valid_o  = valid_r;
  assign Fetch_Error_o  = err_r;

endmodule
